// File: rtl/inst_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_queue_pkg
//  Types and constants shared by the instruction queue and the fetch stage.
//   iq_entry_t : one buffered fetch result {pc, inst, adel}
//   IQ_NOP     : instruction word substituted for faulting fetches
//   RESET_PC   : architectural reset vector (also used by fetch)
// -----------------------------------------------------------------------------
package inst_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } iq_entry_t;

    localparam logic [31:0] IQ_NOP   = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

endpackage : inst_queue_pkg

// File: rtl/inst_queue_ram.sv
// -----------------------------------------------------------------------------
// inst_queue_ram
//  DEPTH x iq_entry_t register file for the instruction queue.
//  One synchronous write port and one combinational read port. Every entry is
//  cleared by the asynchronous active-low reset.
//  Ports:
//   clk      in   clock, writes on rising edge
//   resetn   in   asynchronous active-low reset, clears all entries
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   entry to write
//   raddr    in   read address
//   rdata    out  entry at raddr (combinational)
// -----------------------------------------------------------------------------
module inst_queue_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  iq_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output iq_entry_t     rdata
);

    iq_entry_t entry_rd [DEPTH];

    // One register per entry; each has its own write decode so no single
    // process drives the whole array.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            iq_entry_t entry_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    entry_q <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    entry_q <= wdata;
                end
            end

            assign entry_rd[gi] = entry_q;
        end
    endgenerate

    assign rdata = entry_rd[raddr];

endmodule : inst_queue_ram

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//  Instruction queue between fetch and decode. Captures {pc, inst} pairs from
//  instruction memory, buffers up to DEPTH of them and presents them in order
//  to decode over a valid/ready handshake. flush discards all entries.
//  Optional feature: define FETCH_ADEL_CHECK_EN to flag misaligned fetch PCs
//  (out_adel) and replace their instruction word with a NOP.
//  Ports:
//   clk        in   clock
//   resetn     in   asynchronous active-low reset
//   flush      in   synchronous discard of all entries (beats push/pop)
//   in_valid   in   memory response valid
//   in_pc      in   PC of returned instruction
//   in_inst    in   returned instruction word
//   in_ready   out  queue can accept an entry (drives fetch stall when low)
//   out_valid  out  head entry valid
//   out_pc     out  head entry PC
//   out_inst   out  head entry instruction
//   out_adel   out  head entry fetch address error
//   out_ready  in   decode accepts the head entry
//   count      out  number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_inst,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_inst,
    output logic          out_adel,
    input  logic          out_ready,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    logic      push;
    logic      pop;
    logic      fetch_adel;
    iq_entry_t wr_entry;
    iq_entry_t rd_entry;

    // No pass-through when full: readiness depends on occupancy only.
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

`ifdef FETCH_ADEL_CHECK_EN
    assign fetch_adel = (in_pc[1:0] != 2'b00);
`else
    // Held at zero so the adel bit of every entry is a constant and the
    // storage for it disappears.
    assign fetch_adel = 1'b0;
`endif

    always_comb begin
        wr_entry      = '0;
        wr_entry.pc   = in_pc;
        wr_entry.adel = fetch_adel;
        wr_entry.inst = fetch_adel ? IQ_NOP : in_inst;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Storage is left as-is; only the bookkeeping is cleared.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .we     (push & ~flush),
        .waddr  (wr_ptr_q),
        .wdata  (wr_entry),
        .raddr  (rd_ptr_q),
        .rdata  (rd_entry)
    );

    assign out_pc   = rd_entry.pc;
    assign out_inst = rd_entry.inst;
    assign out_adel = rd_entry.adel;
    assign count    = count_q;

endmodule : inst_queue

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adel;
    logic        out_ready;
    logic [2:0]  count;

    int tests_run;
    int tests_failed;

    inst_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_adel  (out_adel),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; leave time 1 ns past the edge for driving and sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        out_ready = 1'b0;

        // T1 reset
        #12;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc",    64'(out_pc),    64'h0);
        check("rst_out_inst",  64'(out_inst),  64'h0);
        check("rst_out_adel",  64'(out_adel),  64'd0);
        resetn = 1'b1;
        step();
        check("t1_in_ready",  64'(in_ready),  64'd1);
        check("t1_out_valid", 64'(out_valid), 64'd0);
        check("t1_count",     64'(count),     64'd0);
        check("t1_out_pc",    64'(out_pc),    64'h0);

        // T2 fill
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = RESET_PC + 32'(4 * i);
            in_inst  = 32'h100 + 32'(i);
            check("t2_in_ready", 64'(in_ready), 64'd1);
            step();
            check("t2_count", 64'(count), 64'(i + 1));
            check("t2_out_valid", 64'(out_valid), 64'd1);
        end
        check("t2_full_in_ready", 64'(in_ready), 64'd0);
        in_pc   = 32'hbfc0_0010;
        in_inst = 32'h104;
        step();
        in_valid = 1'b0;
        check("t2_fifth_count", 64'(count), 64'd4);
        check("t2_head_pc",     64'(out_pc), 64'hbfc0_0000);

        // T3 drain
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_out_valid", 64'(out_valid), 64'd1);
            check("t3_out_pc",    64'(out_pc),    64'(32'hbfc0_0000 + 32'(4 * i)));
            check("t3_out_inst",  64'(out_inst),  64'(32'h100 + 32'(i)));
            check("t3_out_adel",  64'(out_adel),  64'd0);
            step();
        end
        check("t3_empty_valid", 64'(out_valid), 64'd0);
        check("t3_empty_count", 64'(count),     64'd0);
        step();
        check("t3_pop_empty_count", 64'(count),  64'd0);
        check("t3_stale_pc",        64'(out_pc), 64'hbfc0_0000);
        out_ready = 1'b0;

        // T4 streaming across wrap
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_pc    = 32'h1000 + 32'(4 * k);
            in_inst  = 32'h200 + 32'(k);
            step();
        end
        check("t4_prefill_count", 64'(count), 64'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_pc   = 32'h1000 + 32'(4 * (k + 2));
            in_inst = 32'h200 + 32'(k + 2);
            check("t4_out_pc", 64'(out_pc), 64'(32'h1000 + 32'(4 * k)));
            step();
            check("t4_count", 64'(count), 64'd2);
        end
        in_valid = 1'b0;
        for (int k = 10; k < 12; k++) begin
            check("t4_tail_pc",   64'(out_pc),   64'(32'h1000 + 32'(4 * k)));
            check("t4_tail_inst", 64'(out_inst), 64'(32'h200 + 32'(k)));
            step();
        end
        check("t4_end_count", 64'(count), 64'd0);
        out_ready = 1'b0;

        // T5 flush with concurrent push and pop
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_pc    = 32'h2000 + 32'(4 * k);
            in_inst  = 32'h300 + 32'(k);
            step();
        end
        check("t5_pre_count", 64'(count), 64'd3);
        flush     = 1'b1;
        in_pc     = 32'h200c;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t5_count",     64'(count),     64'd0);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_in_ready",  64'(in_ready),  64'd1);
        in_valid = 1'b1;
        in_pc    = 32'hbfc0_0100;
        in_inst  = 32'h55;
        step();
        in_valid = 1'b0;
        check("t5_first_pc", 64'(out_pc), 64'hbfc0_0100);
        check("t5_count1",   64'(count),  64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t5_drained", 64'(count), 64'd0);

        // T6 misaligned fetch PC
        in_valid = 1'b1;
        in_pc    = 32'hbfc0_0002;
        in_inst  = 32'h2402_0001;
        step();
        in_valid = 1'b0;
        check("t6_out_pc", 64'(out_pc), 64'hbfc0_0002);
`ifdef FETCH_ADEL_CHECK_EN
        check("t6_out_adel", 64'(out_adel), 64'd1);
        check("t6_out_inst", 64'(out_inst), 64'h0);
`else
        check("t6_out_adel", 64'(out_adel), 64'd0);
        check("t6_out_inst", 64'(out_inst), 64'h2402_0001);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset mid-stream, with flush asserted alongside
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_pc    = 32'h4000 + 32'(4 * k);
            in_inst  = 32'h400 + 32'(k);
            step();
        end
        in_valid = 1'b0;
        check("t7_pre_count", 64'(count), 64'd2);
        #2;
        resetn = 1'b0;
        flush  = 1'b1;
        #1;
        check("t7_async_count", 64'(count),     64'd0);
        check("t7_async_valid", 64'(out_valid), 64'd0);
        check("t7_async_pc",    64'(out_pc),    64'h0);
        step();
        resetn = 1'b1;
        flush  = 1'b0;
        step();
        check("t7_post_count", 64'(count),    64'd0);
        check("t7_post_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_pc    = 32'h5000;
        in_inst  = 32'h500;
        step();
        in_valid = 1'b0;
        check("t7_resume_pc",   64'(out_pc),   64'h5000);
        check("t7_resume_inst", 64'(out_inst), 64'h500);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_inst_queue
